fetch_unit: RTL and testbench

Instruction fetch unit: owns the program counter, issues single-outstanding word fetches to instruction memory, and presents each fetched instruction and its PC to decode. It is the receiving end of the jump/branch unit's resolution outputs. A taken jump or branch (`jack` with `je`) redirects the PC and squashes any fetch in flight or instruction buffered.

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, one-entry decode buffer.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirect targets into ERR.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            jack,
    input  logic            je,
    input  logic [XLEN-1:0] jump_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            misalign
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        ERR
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            squash_q, squash_d;
    logic            mis_q, mis_d;

    logic            redir;
    logic            bad;
    logic [XLEN-1:0] tgt;

    assign redir = jack & je;

`ifdef FETCH_ALIGN_CHECK_EN
    assign bad = redir & (jump_addr[1:0] != 2'b00);
    assign tgt = jump_addr;
`else
    assign bad = 1'b0;
    assign tgt = jump_addr & ~XLEN'(3);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            instr_q  <= '0;
            ipc_q    <= '0;
            squash_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            squash_q <= squash_d;
            mis_q    <= mis_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        ipc_d       = ipc_q;
        squash_d    = squash_q;
        mis_d       = mis_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bad) begin
                    mis_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    pc_d    = redir ? tgt : pc_q;
                    addr_d  = redir ? tgt : pc_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (bad) begin
                    // Outstanding request must still finish; ERR keeps it up.
                    mis_d    = 1'b1;
                    squash_d = ~imem_ack;
                    state_d  = ERR;
                end else if (imem_ack) begin
                    if (squash_q || redir) begin
                        squash_d = 1'b0;
                        pc_d     = redir ? tgt : pc_q;
                        addr_d   = redir ? tgt : pc_q;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = addr_q;
                        pc_d    = addr_q + XLEN'(4);
                        state_d = HOLD;
                    end
                end else if (redir) begin
                    pc_d     = tgt;
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (bad) begin
                    mis_d   = 1'b1;
                    state_d = ERR;
                end else if (redir) begin
                    pc_d    = tgt;
                    addr_d  = tgt;
                    state_d = REQ;
                end else if (instr_ready) begin
                    addr_d  = pc_q;
                    state_d = REQ;
                end
            end
            ERR: begin
                imem_req = squash_q;
                if (imem_ack) begin
                    squash_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr = addr_q & ~XLEN'(3);
    assign instr     = instr_q;
    assign instr_pc  = ipc_q;
    assign misalign  = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit, RESET_PC = 0x100.
// Inputs change and outputs are checked at the falling edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        jack;
    logic        je;
    logic [31:0] jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .XLEN    (32),
        .RESET_PC(32'h100)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .jack       (jack),
        .je         (je),
        .jump_addr  (jump_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        jack        = 1'b0;
        je          = 1'b0;
        jump_addr   = '0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b1;
        step();
        step();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL reset_req: req=%b addr=%h want 0/00000100",
                     imem_req, imem_addr);
        end
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 ||
            instr_pc !== 32'h0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: v=%b i=%h pc=%h m=%b want 0/0/0/0",
                     instr_valid, instr, instr_pc, misalign);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h want 1/00000100",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        imem_ack   = 1'b1;
        imem_rdata = word(32'h100);
        step();
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 ||
            instr !== word(32'h100) || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_100: v=%b pc=%h i=%h req=%b want 1/100/%h/0",
                     instr_valid, instr_pc, instr, imem_req, word(32'h100));
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h104 ||
            instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_104: req=%b addr=%h v=%b want 1/104/0",
                     imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_ack_wait();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
                errors++;
                $display("FAIL wait_104[%0d]: req=%b addr=%h want 1/104",
                         i, imem_req, imem_addr);
            end
            imem_ack   = (i == 3);
            imem_rdata = word(32'h104);
            step();
        end
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h104 ||
            instr !== word(32'h104)) begin
            errors++;
            $display("FAIL hold_104: v=%b pc=%h i=%h want 1/104/%h",
                     instr_valid, instr_pc, instr, word(32'h104));
        end
    endtask

    task automatic test_not_taken();
        instr_ready = 1'b0;
        jack        = 1'b1;
        je          = 1'b0;
        jump_addr   = 32'h400;
        step();
        jack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h104 ||
            imem_req !== 1'b0) begin
            errors++;
            $display("FAIL not_taken_hold: v=%b pc=%h req=%b want 1/104/0",
                     instr_valid, instr_pc, imem_req);
        end
        instr_ready = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin
            errors++;
            $display("FAIL not_taken_next: req=%b addr=%h want 1/108",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_squash_req();
        jack      = 1'b1;
        je        = 1'b1;
        jump_addr = 32'h200;
        step();
        jack = 1'b0;
        je   = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin
            errors++;
            $display("FAIL squash_stable1: req=%b addr=%h want 1/108",
                     imem_req, imem_addr);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin
            errors++;
            $display("FAIL squash_stable2: req=%b addr=%h want 1/108",
                     imem_req, imem_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word(32'h108);
        step();
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 ||
            imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL squash_next: v=%b req=%b addr=%h want 0/1/200",
                     instr_valid, imem_req, imem_addr);
        end
        imem_rdata = word(32'h200);
        step();
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 ||
            instr !== word(32'h200)) begin
            errors++;
            $display("FAIL hold_200: v=%b pc=%h i=%h want 1/200/%h",
                     instr_valid, instr_pc, instr, word(32'h200));
        end
    endtask

    task automatic test_redirect_hold();
        instr_ready = 1'b1;
        jack        = 1'b1;
        je          = 1'b1;
        jump_addr   = 32'h300;
        step();
        jack = 1'b0;
        je   = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 ||
            imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL redir_hold: v=%b req=%b addr=%h want 0/1/300",
                     instr_valid, imem_req, imem_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word(32'h300);
        step();
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin
            errors++;
            $display("FAIL hold_300: v=%b pc=%h want 1/300",
                     instr_valid, instr_pc);
        end
    endtask

    task automatic test_misalign();
        jack      = 1'b1;
        je        = 1'b1;
        jump_addr = 32'h202;
        step();
        jack = 1'b0;
        je   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (misalign !== 1'b1 || imem_req !== 1'b0 ||
                instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_err[%0d]: m=%b req=%b v=%b want 1/0/0",
                         i, misalign, imem_req, instr_valid);
            end
            step();
        end
`else
        checks++;
        if (misalign !== 1'b0 || imem_req !== 1'b1 ||
            imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL misalign_mask: m=%b req=%b addr=%h want 0/1/200",
                     misalign, imem_req, imem_addr);
        end
`endif
    endtask

    task automatic test_reset_abort();
        reset_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h100 ||
            misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: req=%b addr=%h m=%b want 0/100/0",
                     imem_req, imem_addr, misalign);
        end
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL rerun_req: req=%b addr=%h want 1/100",
                     imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ack_wait();
        test_not_taken();
        test_squash_req();
        test_redirect_hold();
        test_misalign();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
